serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor that computes A − B LSB-first, one bit per clock, using a single full-subtractor cell with a registered borrow. It is the sequential stage that drives the full-subtractor cell: it loads operands, presents one bit pair plus the stored borrow each cycle, and collects difference bits into a result word. It trades WIDTH cycles of latency for a single-bit datapath.

---
 rtl/serial_subtractor.sv | 107 ++++++++++
 tb/tb_serial_subtractor.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: A - B, LSB first, one bit per clock via a single full-subtractor cell.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
   output logic             ovf,
`endif
   output logic             borrow_out
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] sa, sb, sd, sd_next;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             d, bo, last;
`ifdef SERIAL_SUB_OVF_EN
   logic             a_msb, b_msb;
`endif

   always_comb begin
      d    = sa[0] ^ sb[0] ^ br;
      bo   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
      last = (cnt == CW'(WIDTH - 1));
      // Difference bits enter at the MSB so the word is aligned after WIDTH shifts.
      sd_next            = sd >> 1;
      sd_next[WIDTH-1]   = d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         sa         <= '0;
         sb         <= '0;
         sd         <= '0;
         br         <= 1'b0;
         cnt        <= '0;
`ifdef SERIAL_SUB_OVF_EN
         ovf        <= 1'b0;
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               done <= 1'b0;
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  sd    <= '0;
                  br    <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                  a_msb <= a[WIDTH-1];
                  b_msb <= b[WIDTH-1];
`endif
               end else begin
                  state <= S_IDLE;
               end
            end
            S_SHIFT: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               sd  <= sd_next;
               br  <= bo;
               cnt <= cnt + 1'b1;
               if (last) begin
                  diff       <= sd_next;
                  borrow_out <= bo;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  state      <= S_DONE;
`ifdef SERIAL_SUB_OVF_EN
                  ovf        <= (a_msb != b_msb) && (d != a_msb);
`endif
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); ovf checks compile in with SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n, start;
   logic [W-1:0] a, b;
   logic         busy, done, borrow_out;
   logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int errors = 0;
   int checks = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff),
`ifdef SERIAL_SUB_OVF_EN
      .ovf(ovf),
`endif
      .borrow_out(borrow_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept an operation, verify busy for 8 cycles, then the done cycle and results.
   task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] ed, input logic eb, input logic eo);
      a = av; b = bv; start = 1'b1;
      tick();
      start = 1'b0; a = 'x; b = 'x;
      chk({tag, "_busy0"}, busy, 1);
      chk({tag, "_done0"}, done, 0);
      for (int i = 1; i <= W; i++) begin
         tick();
         if (i < W) begin
            if (busy !== 1'b1 || done !== 1'b0) chk({tag, "_busy_run"}, {busy, done}, 2'b10);
         end else begin
            chk({tag, "_done"}, done, 1);
            chk({tag, "_busy_at_done"}, busy, 0);
            chk({tag, "_diff"}, diff, ed);
            chk({tag, "_bout"}, borrow_out, eb);
`ifdef SERIAL_SUB_OVF_EN
            chk({tag, "_ovf"}, ovf, eo);
`endif
         end
      end
      tick();
      chk({tag, "_done_fall"}, done, 0);
      chk({tag, "_diff_hold"}, diff, ed);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", diff, 0);
      chk("rst_bout", borrow_out, 0);
`ifdef SERIAL_SUB_OVF_EN
      chk("rst_ovf", ovf, 0);
`endif
      rst_n = 1'b1;
      tick();
      chk("idle_busy", busy, 0);

      run_op("basic", 8'd5, 8'd3, 8'd2, 1'b0, 1'b0);
      run_op("borrow", 8'd3, 8'd5, 8'hFE, 1'b1, 1'b0);
      run_op("ovf", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
      run_op("zero", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      run_op("pos_ovf", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

      // Start while busy: second request at cycle 3 must be dropped.
      a = 8'd200; b = 8'd100; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      a = 8'd1; b = 8'd2; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 4; i <= W; i++) tick();
      chk("sb_done", done, 1);
      chk("sb_diff", diff, 8'd100);
      chk("sb_bout", borrow_out, 0);
      tick();
      chk("sb_no_restart", busy, 0);
      chk("sb_done_fall", done, 0);
      tick(); tick();
      chk("sb_idle", busy, 0);

      // Back-to-back with start held high.
      a = 8'd9; b = 8'd4; start = 1'b1;
      tick();
      chk("b2b_busy", busy, 1);
      for (int i = 1; i < W; i++) tick();
      chk("b2b_pre_done", done, 0);
      tick();
      chk("b2b_done1", done, 1);
      chk("b2b_diff1", diff, 8'd5);
      chk("b2b_bout1", borrow_out, 0);
      a = 8'd0; b = 8'd1;
      tick();
      chk("b2b_restart_busy", busy, 1);
      chk("b2b_restart_done", done, 0);
      chk("b2b_diff_hold", diff, 8'd5);
      start = 1'b0;
      for (int i = 1; i < W; i++) tick();
      chk("b2b_pre_done2", done, 0);
      tick();
      chk("b2b_done2", done, 1);
      chk("b2b_diff2", diff, 8'hFF);
      chk("b2b_bout2", borrow_out, 1);
      tick();
      chk("b2b_end", done, 0);

      // Reset mid-operation discards the op and clears outputs.
      a = 8'd50; b = 8'd20; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_diff", diff, 0);
      chk("mrst_bout", borrow_out, 0);
`ifdef SERIAL_SUB_OVF_EN
      chk("mrst_ovf", ovf, 0);
`endif
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done !== 1'b0 || busy !== 1'b0) chk("mrst_quiet", {busy, done}, 2'b00);
      end
      chk("mrst_idle", busy, 0);
      run_op("after_rst", 8'd7, 8'd7, 8'd0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
